// File: rtl/baccarat_pkg.sv
// rtl/baccarat_pkg.sv - shared types and constants for the Baccarat deal sequencer
//
// Contents: deal_state_t state enum, card code constants, rule thresholds,
// and card_value() which maps a card code to its Baccarat point value.
package baccarat_pkg;

    typedef enum logic [2:0] {
        S_P1,
        S_D1,
        S_P2,
        S_D2,
        S_EVAL,
        S_BEVAL,
        S_RESULT,
        S_DONE
    } deal_state_t;

    localparam logic [3:0] CARD_EMPTY = 4'd0;
    localparam logic [3:0] CARD_ACE   = 4'd1;
    localparam logic [3:0] CARD_TEN   = 4'd10;
    localparam logic [3:0] CARD_JACK  = 4'd11;
    localparam logic [3:0] CARD_QUEEN = 4'd12;
    localparam logic [3:0] CARD_KING  = 4'd13;

    localparam logic [3:0] NATURAL_MIN      = 4'd8;
    localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;
    // Highest banker score at which the banker draws when the player stood.
    localparam logic [3:0] BANKER_DRAW_MAX  = 4'd5;

    // Tens and court cards count zero; every other code counts its face value.
    function automatic logic [3:0] card_value(input logic [3:0] code);
        if (code >= CARD_TEN && code <= CARD_KING) begin
            return 4'd0;
        end
        return code;
    endfunction

endpackage

// File: rtl/banker_draw_rule.sv
// rtl/banker_draw_rule.sv - combinational banker third-card draw decision
//
// Ports:
//   dscore  in  4 : banker (dealer) hand score
//   pcard3  in  4 : player third-card code
//   draw    out 1 : banker takes a third card
// Build option BANKER_RULE_EN: defined selects the full banker table keyed on
// the player's third card; undefined draws on dscore 0-5 only.
module banker_draw_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

`ifdef BANKER_RULE_EN
    logic [3:0] value;

    assign value = card_value(pcard3);

    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (value != 4'd8);
            4'd4:             draw = (value >= 4'd2) && (value <= 4'd7);
            4'd5:             draw = (value >= 4'd4) && (value <= 4'd7);
            4'd6:             draw = (value >= 4'd6) && (value <= 4'd7);
            // 7 stands; out-of-range scores also stand so nothing locks up.
            default:          draw = 1'b0;
        endcase
    end
`else
    logic unused_pcard3;

    assign unused_pcard3 = ^pcard3;
    assign draw          = (dscore <= BANKER_DRAW_MAX);
`endif

endmodule

// File: rtl/deal_sequencer.sv
// rtl/deal_sequencer.sv - Baccarat (Punto Banco) deal and win-light controller
//
// Ports:
//   slow_clock        in  1 : system clock, rising edge
//   reset             in  1 : asynchronous active-high reset, returns to S_P1
//   step              in  1 : advance pulse from the debounced key
//   pscore, dscore    in  4 : player / dealer hand scores from the datapath
//   pcard3            in  4 : player third-card code
//   load_pcard1..3    out 1 : registered one-cycle player card load strobes
//   load_dcard1..3    out 1 : registered one-cycle dealer card load strobes
//   player_win_light  out 1 : player wins (with dealer_win_light on a tie)
//   dealer_win_light  out 1 : dealer wins
//   done              out 1 : hand complete
// Build option BANKER_RULE_EN selects the full banker table in banker_draw_rule.
module deal_sequencer
    import baccarat_pkg::*;
(
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       step,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       done
);

    // Strobe vector order: pcard1, dcard1, pcard2, dcard2, pcard3, dcard3.
    localparam logic [5:0] LD_P1 = 6'b100000;
    localparam logic [5:0] LD_D1 = 6'b010000;
    localparam logic [5:0] LD_P2 = 6'b001000;
    localparam logic [5:0] LD_D2 = 6'b000100;
    localparam logic [5:0] LD_P3 = 6'b000010;
    localparam logic [5:0] LD_D3 = 6'b000001;

    deal_state_t state, state_next;
    logic [5:0]  strobe, strobe_next;
    logic        enter_done;
    logic        accept;
    logic        banker_draw;
    logic        natural;

    banker_draw_rule u_banker_draw_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (banker_draw)
    );

    // A step during a strobe cycle is dropped so the datapath score reflects
    // the freshly loaded card before the next decision is taken.
    assign accept  = step && (strobe == 6'b0);
    assign natural = (pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN);

    always_comb begin
        state_next  = state;
        strobe_next = 6'b0;
        enter_done  = 1'b0;
        if (accept) begin
            case (state)
                S_P1: begin
                    strobe_next = LD_P1;
                    state_next  = S_D1;
                end
                S_D1: begin
                    strobe_next = LD_D1;
                    state_next  = S_P2;
                end
                S_P2: begin
                    strobe_next = LD_P2;
                    state_next  = S_D2;
                end
                S_D2: begin
                    strobe_next = LD_D2;
                    state_next  = S_EVAL;
                end
                S_EVAL: begin
                    if (natural) begin
                        state_next = S_DONE;
                        enter_done = 1'b1;
                    end else if (pscore < PLAYER_STAND_MIN) begin
                        strobe_next = LD_P3;
                        state_next  = S_BEVAL;
                    end else if (dscore <= BANKER_DRAW_MAX) begin
                        strobe_next = LD_D3;
                        state_next  = S_RESULT;
                    end else begin
                        state_next = S_DONE;
                        enter_done = 1'b1;
                    end
                end
                S_BEVAL: begin
                    if (banker_draw) begin
                        strobe_next = LD_D3;
                        state_next  = S_RESULT;
                    end else begin
                        state_next = S_DONE;
                        enter_done = 1'b1;
                    end
                end
                S_RESULT: begin
                    state_next = S_DONE;
                    enter_done = 1'b1;
                end
                default: begin
                    state_next = S_DONE;
                end
            endcase
        end
    end

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            state            <= S_P1;
            strobe           <= 6'b0;
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
            done             <= 1'b0;
        end else begin
            state  <= state_next;
            strobe <= strobe_next;
            if (enter_done) begin
                player_win_light <= (pscore >= dscore);
                dealer_win_light <= (dscore >= pscore);
                done             <= 1'b1;
            end
        end
    end

    assign {load_pcard1, load_dcard1, load_pcard2,
            load_dcard2, load_pcard3, load_dcard3} = strobe;

endmodule

// File: tb/tb_deal_sequencer.sv
// tb/tb_deal_sequencer.sv - table-driven self-checking bench for deal_sequencer
module tb_deal_sequencer;
    import baccarat_pkg::*;

    logic       slow_clock;
    logic       reset;
    logic       step;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light, done;

    deal_sequencer dut (
        .slow_clock       (slow_clock),
        .reset            (reset),
        .step             (step),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .done             (done)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    localparam logic [5:0] M_NONE = 6'b000000;
    localparam logic [5:0] M_P1   = 6'b100000;
    localparam logic [5:0] M_D1   = 6'b010000;
    localparam logic [5:0] M_P2   = 6'b001000;
    localparam logic [5:0] M_D2   = 6'b000100;
    localparam logic [5:0] M_PC3  = 6'b000010;
    localparam logic [5:0] M_DC3  = 6'b000001;

    typedef struct {
        string           name;
        int              n;
        logic [2:0][3:0] p;
        logic [2:0][3:0] d;
        logic [2:0][5:0] m;
        logic [3:0]      c3;
        logic            pw;
        logic            dw;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [5:0] mask();
        return {load_pcard1, load_dcard1, load_pcard2,
                load_dcard2, load_pcard3, load_dcard3};
    endfunction

    function automatic vec_t mk(string name, int n,
                                logic [3:0] p0, logic [3:0] d0, logic [5:0] m0,
                                logic [3:0] p1, logic [3:0] d1, logic [5:0] m1,
                                logic [3:0] p2, logic [3:0] d2, logic [5:0] m2,
                                logic [3:0] c3, logic pw, logic dw);
        vec_t v;
        v.name = name;
        v.n    = n;
        v.p    = {p2, p1, p0};
        v.d    = {d2, d1, d0};
        v.m    = {m2, m1, m0};
        v.c3   = c3;
        v.pw   = pw;
        v.dw   = dw;
        return v;
    endfunction

    task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step  = 1'b0;
        @(negedge slow_clock);
        @(negedge slow_clock);
        reset = 1'b0;
    endtask

    // One accepted step; on return the strobe it caused is visible.
    task automatic do_step();
        @(negedge slow_clock);
        step = 1'b1;
        @(negedge slow_clock);
        step = 1'b0;
    endtask

    task automatic deal_four(string nm);
        do_step(); check({nm, ".p1"}, 16'(mask()), 16'(M_P1));
        do_step(); check({nm, ".d1"}, 16'(mask()), 16'(M_D1));
        do_step(); check({nm, ".p2"}, 16'(mask()), 16'(M_P2));
        do_step(); check({nm, ".d2"}, 16'(mask()), 16'(M_D2));
    endtask

    initial begin
        reset  = 1'b1;
        step   = 1'b0;
        pscore = 4'd0;
        dscore = 4'd0;
        pcard3 = CARD_EMPTY;

        vecs.push_back(mk("natural_p8", 1, 8,3,M_NONE, 0,0,M_NONE, 0,0,M_NONE, 0, 1,0));
        vecs.push_back(mk("natural_d9", 1, 3,9,M_NONE, 0,0,M_NONE, 0,0,M_NONE, 0, 0,1));
        vecs.push_back(mk("p_draw_b_draw", 3, 4,3,M_PC3, 9,3,M_DC3, 9,4,M_NONE, 5, 1,0));
        vecs.push_back(mk("b_stand_queen", 2, 2,6,M_PC3, 2,6,M_NONE, 0,0,M_NONE, 12, 0,1));
        vecs.push_back(mk("p_stand_b_draw", 2, 6,4,M_DC3, 6,7,M_NONE, 0,0,M_NONE, 0, 0,1));
        vecs.push_back(mk("tie_stand", 1, 7,7,M_NONE, 0,0,M_NONE, 0,0,M_NONE, 0, 1,1));
        vecs.push_back(mk("d7_stand", 2, 4,7,M_PC3, 4,7,M_NONE, 0,0,M_NONE, 2, 0,1));
`ifdef BANKER_RULE_EN
        vecs.push_back(mk("d3_c8", 2, 5,3,M_PC3, 7,3,M_NONE, 0,0,M_NONE, 8, 1,0));
        vecs.push_back(mk("d5_c3", 2, 3,5,M_PC3, 6,5,M_NONE, 0,0,M_NONE, 3, 1,0));
        vecs.push_back(mk("d4_jack", 2, 1,4,M_PC3, 1,4,M_NONE, 0,0,M_NONE, 11, 0,1));
        vecs.push_back(mk("d6_c7", 3, 0,6,M_PC3, 7,6,M_DC3, 7,8,M_NONE, 7, 0,1));
`else
        vecs.push_back(mk("d3_c8", 3, 5,3,M_PC3, 7,3,M_DC3, 7,7,M_NONE, 8, 1,1));
        vecs.push_back(mk("d5_c3", 3, 3,5,M_PC3, 6,5,M_DC3, 6,5,M_NONE, 3, 1,0));
        vecs.push_back(mk("d4_jack", 3, 1,4,M_PC3, 1,4,M_DC3, 1,4,M_NONE, 11, 0,1));
        vecs.push_back(mk("d6_c7", 2, 0,6,M_PC3, 7,6,M_NONE, 0,0,M_NONE, 7, 1,0));
`endif

        // Reset state.
        @(negedge slow_clock);
        check("reset_outputs",
              16'({mask(), player_win_light, dealer_win_light, done}), 16'd0);

        foreach (vecs[k]) begin
            do_reset();
            pscore = 4'd0;
            dscore = 4'd0;
            pcard3 = CARD_EMPTY;
            deal_four(vecs[k].name);
            check({vecs[k].name, ".done_early"}, 16'(done), 16'd0);
            for (int i = 0; i < vecs[k].n; i++) begin
                pscore = vecs[k].p[i];
                dscore = vecs[k].d[i];
                pcard3 = vecs[k].c3;
                do_step();
                check($sformatf("%s.step%0d", vecs[k].name, i),
                      16'(mask()), 16'(vecs[k].m[i]));
            end
            @(negedge slow_clock);
            check({vecs[k].name, ".result"},
                  16'({player_win_light, dealer_win_light, done}),
                  16'({vecs[k].pw, vecs[k].dw, 1'b1}));
        end

        // Terminal state: further steps change nothing (last hand's result held).
        pscore = 4'd0;
        dscore = 4'd9;
        do_step();
        check("terminal_strobe", 16'(mask()), 16'(M_NONE));
        do_step();
        check("terminal_hold",
              16'({player_win_light, dealer_win_light, done}),
              16'({vecs[vecs.size()-1].pw, vecs[vecs.size()-1].dw, 1'b1}));

        // Step held for three edges: accept, ignored while busy, accept.
        do_reset();
        @(negedge slow_clock);
        step = 1'b1;
        @(negedge slow_clock);
        check("held_first", 16'(mask()), 16'(M_P1));
        @(negedge slow_clock);
        check("held_busy_ignored", 16'(mask()), 16'(M_NONE));
        @(negedge slow_clock);
        check("held_second", 16'(mask()), 16'(M_D1));
        step = 1'b0;
        do_step();
        check("held_then_p2", 16'(mask()), 16'(M_P2));

        // Reset while the S_P2 strobe is high clears it immediately.
        do_reset();
        do_step();
        do_step();
        do_step();
        check("midreset_strobe_high", 16'(mask()), 16'(M_P2));
        reset = 1'b1;
        #1;
        check("midreset_cleared", 16'(mask()), 16'(M_NONE));
        @(negedge slow_clock);
        reset = 1'b0;
        do_step();
        check("midreset_restart_p1", 16'(mask()), 16'(M_P1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
